// File: rtl/gray_frame_arbiter.sv
// gray_frame_arbiter: frame-granular two-source arbiter in front of the
// RGB565-to-grey pipeline. A whole frame (sop..eop) from one source is
// forwarded through a registered mux with 1-cycle latency. A frame that
// starts while the other source holds the grant, or while en=0 in IDLE,
// is dropped and counted.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   en                      1 = new grants allowed
//   s0_*/s1_*               source pixel, valid, sop, eop
//   dout, dout_vld/sop/eop  forwarded beat (dout holds when dout_vld=0)
//   dout_src                source of current/last forwarded beat
//   busy                    1 while a frame is granted (aligned with dout)
//   drop0_cnt, drop1_cnt    saturating dropped-frame counters
//   abort                   watchdog abort pulse
//
// Build option: define GRAY_FRAME_ARB_WDOG_EN to add the idle watchdog.
// Without it abort is tied to 0 and the grant holds until eop or reset.
module gray_frame_arbiter #(
    parameter int DW      = 16,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DW-1:0]    s0_din,
    input  logic             s0_vld,
    input  logic             s0_sop,
    input  logic             s0_eop,
    input  logic [DW-1:0]    s1_din,
    input  logic             s1_vld,
    input  logic             s1_sop,
    input  logic             s1_eop,
    output logic [DW-1:0]    dout,
    output logic             dout_vld,
    output logic             dout_sop,
    output logic             dout_eop,
    output logic             dout_src,
    output logic             busy,
    output logic [CNT_W-1:0] drop0_cnt,
    output logic [CNT_W-1:0] drop1_cnt,
    output logic             abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             ptr_q, ptr_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             src_q, src_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] drop0_q, drop0_d;
    logic [CNT_W-1:0] drop1_q, drop1_d;

    logic st0, st1;
    logic fwd, fsel;
    logic inc0, inc1;
    logic sel_vld;

    assign st0 = s0_vld & s0_sop;
    assign st1 = s1_vld & s1_sop;

`ifdef GRAY_FRAME_ARB_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            abort_q, abort_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = 1'b0;
        fwd     = 1'b0;
        fsel    = 1'b0;
        inc0    = 1'b0;
        inc1    = 1'b0;
`ifdef GRAY_FRAME_ARB_WDOG_EN
        wd_d    = wd_q;
        abort_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef GRAY_FRAME_ARB_WDOG_EN
                wd_d = '0;
`endif
                if (en && (st0 || st1)) begin
                    // simultaneous starts go to the preferred source
                    fsel   = (st0 && st1) ? ptr_q : st1;
                    fwd    = 1'b1;
                    busy_d = 1'b1;
                    inc0   = st0 & fsel;
                    inc1   = st1 & ~fsel;
                    ptr_d  = ~fsel;
                    // single-beat frame never leaves IDLE
                    if (!(fsel ? s1_eop : s0_eop))
                        state_d = fsel ? GNT1 : GNT0;
                end else if (!en) begin
                    inc0 = st0;
                    inc1 = st1;
                end
            end
            GNT0, GNT1: begin
                fsel   = (state_q == GNT1);
                fwd    = 1'b1;
                busy_d = 1'b1;
                inc0   = st0 & fsel;
                inc1   = st1 & ~fsel;
                if (fsel ? (s1_vld & s1_eop) : (s0_vld & s0_eop))
                    state_d = IDLE;
`ifdef GRAY_FRAME_ARB_WDOG_EN
                if (fsel ? s1_vld : s0_vld) begin
                    wd_d = '0;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // abort without eop; prefer the other source next
                    state_d = IDLE;
                    abort_d = 1'b1;
                    busy_d  = 1'b0;
                    ptr_d   = ~fsel;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_vld = fsel ? s1_vld : s0_vld;

    always_comb begin
        dout_d = dout_q;
        vld_d  = 1'b0;
        sop_d  = 1'b0;
        eop_d  = 1'b0;
        src_d  = src_q;
        if (fwd && sel_vld) begin
            dout_d = fsel ? s1_din : s0_din;
            vld_d  = 1'b1;
            sop_d  = fsel ? s1_sop : s0_sop;
            eop_d  = fsel ? s1_eop : s0_eop;
            src_d  = fsel;
        end
    end

    always_comb begin
        drop0_d = drop0_q;
        drop1_d = drop1_q;
        if (inc0 && (drop0_q != {CNT_W{1'b1}}))
            drop0_d = drop0_q + 1'b1;
        if (inc1 && (drop1_q != {CNT_W{1'b1}}))
            drop1_d = drop1_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            src_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop0_q <= '0;
            drop1_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            src_q   <= src_d;
            busy_q  <= busy_d;
            drop0_q <= drop0_d;
            drop1_q <= drop1_d;
        end
    end

`ifdef GRAY_FRAME_ARB_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            abort_q <= abort_d;
        end
    end

    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    assign dout      = dout_q;
    assign dout_vld  = vld_q;
    assign dout_sop  = sop_q;
    assign dout_eop  = eop_q;
    assign dout_src  = src_q;
    assign busy      = busy_q;
    assign drop0_cnt = drop0_q;
    assign drop1_cnt = drop1_q;

endmodule

// File: tb/tb_gray_frame_arbiter.sv
// tb_gray_frame_arbiter: vector table, directed corner sequences and
// random traffic checked against a frame-level reference model.
module tb_gray_frame_arbiter;

    localparam int DW      = 16;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b0;
    logic [DW-1:0]   s0_din = '0, s1_din = '0;
    logic            s0_vld = 0, s0_sop = 0, s0_eop = 0;
    logic            s1_vld = 0, s1_sop = 0, s1_eop = 0;
    logic [DW-1:0]   dout;
    logic            dout_vld, dout_sop, dout_eop, dout_src;
    logic            busy, abort;
    logic [CNT_W-1:0] drop0_cnt, drop1_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gray_frame_arbiter #(
        .DW(DW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s0_din(s0_din), .s0_vld(s0_vld),
        .s0_sop(s0_sop), .s0_eop(s0_eop),
        .s1_din(s1_din), .s1_vld(s1_vld),
        .s1_sop(s1_sop), .s1_eop(s1_eop),
        .dout(dout), .dout_vld(dout_vld),
        .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_src(dout_src), .busy(busy),
        .drop0_cnt(drop0_cnt), .drop1_cnt(drop1_cnt),
        .abort(abort)
    );

    // reference model: owner of the current frame (-1 none),
    // preferred source, idle cycles, drop tallies, expected outputs
    int          own, pref, idle, m_d0, m_d1;
    logic [15:0] m_dout;
    bit          m_vld, m_sop, m_eop, m_src, m_busy, m_abort;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp,
                     $time);
        end
    endtask

    function automatic void model_reset();
        own = -1; pref = 0; idle = 0; m_d0 = 0; m_d1 = 0;
        m_dout = '0;
        m_vld = 0; m_sop = 0; m_eop = 0; m_src = 0;
        m_busy = 0; m_abort = 0;
    endfunction

    function automatic void drop(input int s);
        if (s == 0) m_d0 = (m_d0 < 255) ? m_d0 + 1 : 255;
        else        m_d1 = (m_d1 < 255) ? m_d1 + 1 : 255;
    endfunction

    function automatic void model_step();
        bit          v[2], so[2], eo[2], st[2];
        logic [15:0] d[2];
        int          w;
        v[0] = s0_vld; so[0] = s0_sop; eo[0] = s0_eop; d[0] = s0_din;
        v[1] = s1_vld; so[1] = s1_sop; eo[1] = s1_eop; d[1] = s1_din;
        st[0] = v[0] && so[0];
        st[1] = v[1] && so[1];
        m_vld = 0; m_sop = 0; m_eop = 0; m_busy = 0; m_abort = 0;
        w = -1;
        if (own < 0) begin
            if (en && (st[0] || st[1])) begin
                w = (st[0] && st[1]) ? pref : (st[0] ? 0 : 1);
                if (st[1-w]) drop(1 - w);
                pref = 1 - w;
                idle = 0;
                own = eo[w] ? -1 : w;
                m_busy = 1;
            end else if (!en) begin
                if (st[0]) drop(0);
                if (st[1]) drop(1);
            end
        end else begin
            w = own;
            m_busy = 1;
            if (st[1-w]) drop(1 - w);
            if (v[w]) begin
                idle = 0;
                if (eo[w]) own = -1;
            end
`ifdef GRAY_FRAME_ARB_WDOG_EN
            else begin
                idle++;
                if (idle == TIMEOUT) begin
                    own = -1; m_abort = 1; m_busy = 0;
                    pref = 1 - w; idle = 0; w = -1;
                end
            end
`endif
        end
        if (w >= 0 && v[w]) begin
            m_vld = 1; m_sop = so[w]; m_eop = eo[w];
            m_dout = d[w]; m_src = (w == 1);
        end
    endfunction

    task automatic drive(input bit e,
                         input bit a0, b0, c0, input logic [15:0] x0,
                         input bit a1, b1, c1, input logic [15:0] x1);
        en = e;
        s0_vld = a0; s0_sop = b0; s0_eop = c0; s0_din = x0;
        s1_vld = a1; s1_sop = b1; s1_eop = c1; s1_din = x1;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("cycle",
            {dout, dout_vld, dout_sop, dout_eop, dout_src, busy, abort,
             drop0_cnt, drop1_cnt},
            {m_dout, m_vld, m_sop, m_eop, m_src, m_busy, m_abort,
             CNT_W'(m_d0), CNT_W'(m_d1)});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        #1;
        model_reset();
        chk("reset",
            {dout, dout_vld, dout_sop, dout_eop, dout_src, busy, abort,
             drop0_cnt, drop1_cnt}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit rst; bit en;
        bit v0, s0, e0; logic [15:0] d0;
        bit v1, s1, e1; logic [15:0] d1;
        bit xv, xs, xe, xsrc, xb; logic [15:0] xd;
        int xc0, xc1;
    } vec_t;

    function automatic vec_t mk(
        input bit rst, en, v0, s0, e0, input logic [15:0] d0,
        input bit v1, s1, e1, input logic [15:0] d1,
        input bit xv, xs, xe, xsrc, xb, input logic [15:0] xd,
        input int xc0, xc1);
        vec_t r;
        r.rst = rst; r.en = en;
        r.v0 = v0; r.s0 = s0; r.e0 = e0; r.d0 = d0;
        r.v1 = v1; r.s1 = s1; r.e1 = e1; r.d1 = d1;
        r.xv = xv; r.xs = xs; r.xe = xe; r.xsrc = xsrc; r.xb = xb;
        r.xd = xd; r.xc0 = xc0; r.xc1 = xc1;
        return r;
    endfunction

    vec_t tv[13];

    initial begin
        // 4-beat s0 frame
        tv[0]  = mk(1,1, 1,1,0,16'hF800, 0,0,0,16'h0,
                    1,1,0,0,1,16'hF800, 0,0);
        tv[1]  = mk(0,1, 1,0,0,16'h07E0, 0,0,0,16'h0,
                    1,0,0,0,1,16'h07E0, 0,0);
        tv[2]  = mk(0,1, 1,0,0,16'h1234, 0,0,0,16'h0,
                    1,0,0,0,1,16'h1234, 0,0);
        tv[3]  = mk(0,1, 1,0,1,16'h001F, 0,0,0,16'h0,
                    1,0,1,0,1,16'h001F, 0,0);
        tv[4]  = mk(0,1, 0,0,0,16'h0, 0,0,0,16'h0,
                    0,0,0,0,0,16'h001F, 0,0);
        // simultaneous starts: s0 first, then s1
        tv[5]  = mk(1,1, 1,1,0,16'hAAAA, 1,1,0,16'hBBBB,
                    1,1,0,0,1,16'hAAAA, 0,1);
        tv[6]  = mk(0,1, 1,0,1,16'h5555, 1,0,0,16'h6666,
                    1,0,1,0,1,16'h5555, 0,1);
        tv[7]  = mk(0,1, 0,0,0,16'h0, 0,0,0,16'h0,
                    0,0,0,0,0,16'h5555, 0,1);
        tv[8]  = mk(0,1, 1,1,0,16'h7777, 1,1,0,16'h8888,
                    1,1,0,1,1,16'h8888, 1,1);
        tv[9]  = mk(0,1, 0,0,0,16'h0, 1,0,1,16'h9999,
                    1,0,1,1,1,16'h9999, 1,1);
        tv[10] = mk(0,1, 0,0,0,16'h0, 0,0,0,16'h0,
                    0,0,0,1,0,16'h9999, 1,1);
        // single-beat s1 frame
        tv[11] = mk(0,1, 0,0,0,16'h0, 1,1,1,16'h4321,
                    1,1,1,1,1,16'h4321, 1,1);
        tv[12] = mk(0,1, 0,0,0,16'h0, 0,0,0,16'h0,
                    0,0,0,1,0,16'h4321, 1,1);

        #2;
        for (int i = 0; i < 13; i++) begin
            if (tv[i].rst) do_reset();
            drive(tv[i].en, tv[i].v0, tv[i].s0, tv[i].e0, tv[i].d0,
                  tv[i].v1, tv[i].s1, tv[i].e1, tv[i].d1);
            step();
            chk($sformatf("vec%0d", i),
                {dout, dout_vld, dout_sop, dout_eop, dout_src, busy,
                 drop0_cnt, drop1_cnt},
                {tv[i].xd, tv[i].xv, tv[i].xs, tv[i].xe, tv[i].xsrc,
                 tv[i].xb, CNT_W'(tv[i].xc0), CNT_W'(tv[i].xc1)});
        end

        // drop counter saturation during a long s0 frame
        do_reset();
        drive(1, 1, 1, 0, 16'h1111, 0, 0, 0, 16'h0);
        step();
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 0, 0, 16'(i), 1, 1, 0, 16'hBEEF);
            step();
        end
        chk("sat_drop1", drop1_cnt, 64'd255);
        chk("sat_src", {dout_src, dout}, {1'b0, 16'(299)});
        drive(1, 1, 0, 1, 16'h2222, 0, 0, 0, 16'h0);
        step();
        chk("sat_eop", {dout_vld, dout_eop, dout}, {2'b11, 16'h2222});

        // en dropped mid-frame, then a refused start
        drive(1, 1, 1, 0, 16'h3000, 0, 0, 0, 16'h0);
        step();
        drive(0, 1, 0, 0, 16'h3001, 0, 0, 0, 16'h0);
        step();
        drive(0, 1, 0, 1, 16'h3002, 0, 0, 0, 16'h0);
        step();
        chk("en0_eop", {dout_vld, dout_eop, busy, dout},
            {3'b111, 16'h3002});
        drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        step();
        drive(0, 1, 1, 0, 16'h3003, 0, 0, 0, 16'h0);
        step();
        chk("en0_refuse", {dout_vld, busy, drop0_cnt},
            {2'b00, 8'd1});

        // reset in the middle of a frame
        drive(1, 1, 1, 0, 16'h4000, 0, 0, 0, 16'h0);
        step();
        drive(1, 1, 0, 0, 16'h4001, 0, 0, 0, 16'h0);
        step();
        do_reset();

        // silent granted source
        drive(1, 1, 1, 0, 16'h5000, 0, 0, 0, 16'h0);
        step();
        drive(1, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        repeat (15) step();
        chk("wd_pre", {busy, abort}, 2'b10);
        step();
`ifdef GRAY_FRAME_ARB_WDOG_EN
        chk("wd_abort", {busy, abort, dout_vld, dout_eop}, 4'b0100);
        step();
        chk("wd_pulse", abort, 1'b0);
        drive(1, 0, 0, 0, 16'h0, 1, 1, 0, 16'h6000);
        step();
        chk("wd_regrant", {dout_vld, dout_sop, dout_src, busy, dout},
            {4'b1111, 16'h6000});
        drive(1, 0, 0, 0, 16'h0, 1, 0, 1, 16'h6001);
        step();
`else
        chk("wd_hold", {busy, abort}, 2'b10);
        drive(1, 0, 0, 0, 16'h0, 1, 1, 0, 16'h6000);
        step();
        chk("wd_hold_drop", {busy, dout_vld, drop1_cnt},
            {2'b10, 8'd1});
        drive(1, 1, 0, 1, 16'h5001, 0, 0, 0, 16'h0);
        step();
`endif

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0,
                  16'($urandom),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0,
                  16'($urandom));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_frame_arbiter.md
Name: gray_frame_arbiter

Overview:
- Frame-granular arbiter that shares one RGB565 pixel pipeline (the RGB565-to-grey converter feeding edge detection) between two camera/pixel sources.
- Grants a whole frame (sop..eop) to one source and forwards it through a registered mux. Frames from the non-granted source are dropped and counted.
- Streams carry no backpressure, so losing frames are discarded, never stalled.

Parameters:
DW, 16, pixel data width (RGB565)
CNT_W, 8, width of per-source drop counters
TIMEOUT, 4096, idle cycles without granted-source vld before frame abort (watchdog build only)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = new grants allowed; 0 = finish current frame, then grant nothing
s0_din  input  DW  source 0 pixel
s0_vld  input  1  source 0 pixel valid
s0_sop  input  1  source 0 start of frame (qualified by s0_vld)
s0_eop  input  1  source 0 end of frame (qualified by s0_vld)
s1_din, s1_vld, s1_sop, s1_eop  input  DW/1/1/1  source 1, same meaning
dout  output  DW  forwarded pixel to converter
dout_vld  output  1  forwarded valid
dout_sop  output  1  forwarded sop
dout_eop  output  1  forwarded eop
dout_src  output  1  source index of current/last forwarded beat
busy  output  1  1 while a frame is granted
drop0_cnt  output  CNT_W  saturating count of dropped source-0 frames
drop1_cnt  output  CNT_W  saturating count of dropped source-1 frames
abort  output  1  one-cycle pulse when watchdog aborts a frame

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset all outputs are 0, the state is IDLE, and the round-robin pointer prefers source 0.
- States: IDLE, GNT0, GNT1.
- IDLE -> GNTx: when en=1 and sx_vld&sx_sop.
  - If both sources start in the same cycle, grant the source the pointer prefers.
  - The pointer then flips to prefer the other source.
- Single-source grant: the pointer is set to prefer the non-granted source.
- Unmarked beats in IDLE: vld beats without sop are ignored and not counted.
- Forwarding: in GNTx, and on the granting cycle itself, the sx beat is registered to the outputs.
  - Latency is exactly 1 cycle. The sop beat is forwarded, not lost.
  - dout_vld/sop/eop track the registered source qualifiers each cycle; they are 0 when nothing is forwarded.
  - dout holds its last value when dout_vld=0.
- Frame end: in GNTx, sx_vld&sx_eop forwards the beat, then returns to IDLE next cycle. busy is 0 from that next cycle.
- Back-to-back frames: a new sop (either source) in the cycle after eop is arbitrated normally in IDLE. A sop coinciding with the eop cycle is treated as a drop.
- Dropped frames: any vld&sop from the non-granted source, or while en=0 in IDLE, increments that source's drop counter.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - Remaining beats of a dropped frame are ignored.
- Missing eop: a vld&sop from the granted source while in GNTx is forwarded as a new frame start. The grant continues.
- Single-beat frame: sop&eop on the same beat is granted, forwarded, and ends immediately (IDLE next cycle).
- en deassert: en=0 mid-frame does not truncate the frame.
- Reset mid-frame: outputs clear immediately. No eop is emitted and counters clear.

Optional Feature:
- GRAY_FRAME_ARB_WDOG_EN defined:
  - A counter clears on each granted-source vld and increments every cycle in GNTx.
  - When it reaches TIMEOUT: go to IDLE, pulse abort for 1 cycle, emit no dout_eop, and flip the pointer.
- Not defined: no counter; abort is tied to 0; the grant is held until eop or reset.

Test Plan:
- Reset, then s0 frame of 4 beats (sop on 0xF800, eop on 0x001F) -> dout replicates each beat 1 cycle later, dout_src=0, busy 1 for 4 cycles then 0.
- s0 and s1 sop in the same cycle after reset -> s0 granted, s1 frame dropped, drop1_cnt=1. Repeat after frame end -> s1 granted.
- s1 sop during a granted s0 frame, 300 times -> drop1_cnt=255 (saturated), s0 output unaffected.
- en=0 in the middle of an s0 frame -> frame completes with eop. Subsequent s0 sop -> not granted, drop0_cnt increments.
- Single-beat frame (sop&eop) on s1 -> one dout beat with dout_sop=dout_eop=1, busy 1 for exactly 1 cycle.
- With GRAY_FRAME_ARB_WDOG_EN, TIMEOUT=16: s0 sop then no vld for 16 cycles -> abort pulse, IDLE. Next s1 sop granted. Without the macro -> busy stays 1.
